// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each grant drives the ALU for one cycle and holds the result until the requester takes it.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  req1_ready_o,
  output logic                  rsp0_valid_o,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_err_o,
  input  logic                  rsp0_ready_i,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_err_o,
  input  logic                  rsp1_ready_i,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  busy_o
);

  localparam logic [OP_WIDTH-1:0] OP_INVALID = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state, next_state;
  logic                  grant, last_grant;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
  logic                  err_q;

  logic                  winner;
  logic                  accept;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  sel_invalid;
  logic                  rsp_ready_sel;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (req0_valid_i && req1_valid_i) winner = ~last_grant;
    else if (req1_valid_i)            winner = 1'b1;
  end

  assign req0_ready_o  = (state == IDLE) & req0_valid_i & ~winner;
  assign req1_ready_o  = (state == IDLE) & req1_valid_i &  winner;
  assign accept        = req0_ready_o | req1_ready_o;
  assign sel_op        = winner ? req1_op_i : req0_op_i;
  assign sel_a         = winner ? req1_a_i  : req0_a_i;
  assign sel_b         = winner ? req1_b_i  : req0_b_i;
  assign sel_invalid   = (sel_op == OP_INVALID);
  assign rsp_ready_sel = grant ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = sel_invalid ? RESP : ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    if (rsp_ready_sel) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        grant      <= winner;
        last_grant <= winner;
        err_q      <= sel_invalid;
        if (sel_invalid) result_q <= '0;
      end
      if (state == ISSUE) result_q <= alu_result_i;
    end
  end

  assign alu_op_o = (state == ISSUE) ? op_q : OP_INVALID;
  assign alu_a_o  = (state == ISSUE) ? a_q  : '0;
  assign alu_b_o  = (state == ISSUE) ? b_q  : '0;

  assign rsp0_valid_o = (state == RESP) & ~grant;
  assign rsp1_valid_o = (state == RESP) &  grant;
  assign rsp0_data_o  = rsp0_valid_o ? result_q : '0;
  assign rsp1_data_o  = rsp1_valid_o ? result_q : '0;
  assign rsp0_err_o   = rsp0_valid_o & err_q;
  assign rsp1_err_o   = rsp1_valid_o & err_q;
  assign busy_o       = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single-cycle core's one ALU between two requesters, for example the main datapath and an address/debug unit. Each requester hands over an operation code and two operands with a valid/ready handshake. The block drives the shared ALU for exactly one cycle, registers the result, and holds it on that requester's response port until it is accepted.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU operation code width (ALU_Operation encoding; 4'b1111 = invalid)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req0_valid_i / req1_valid_i  in  1  request present
- req0_op_i / req1_op_i  in  OP_WIDTH  requested ALU operation
- req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  DATA_WIDTH  operands
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- rsp0_valid_o / rsp1_valid_o  out  1  result available
- rsp0_data_o / rsp1_data_o  out  DATA_WIDTH  result
- rsp0_err_o / rsp1_err_o  out  1  request carried invalid op 4'b1111
- rsp0_ready_i / rsp1_ready_i  in  1  requester consumes result
- alu_op_o  out  OP_WIDTH  to shared ALU
- alu_a_o, alu_b_o  out  DATA_WIDTH  to shared ALU
- alu_result_i  in  DATA_WIDTH  combinational ALU result
- busy_o  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, RESP. Registers: state, grant (1 bit), last_grant (1 bit), op_q, a_q, b_q, result_q, err_q.
- IDLE, arbitration:
  - One valid request: that requester wins.
  - Both valid: the requester != last_grant wins.
  - reqN_ready_o = (state==IDLE) & reqN_valid_i & (winner==N). At most one ready is high, and only in IDLE.
- Accept (valid & ready):
  - Capture op/a/b into op_q/a_q/b_q; grant <= N; last_grant <= N.
  - If op == 4'b1111: err_q <= 1, result_q <= 0, next RESP (ISSUE skipped).
  - Otherwise: err_q <= 0, next ISSUE.
- ISSUE (one cycle):
  - alu_op_o = op_q, alu_a_o = a_q, alu_b_o = b_q.
  - result_q <= alu_result_i at the end of the cycle; next RESP.
- Outside ISSUE: alu_op_o = 4'b1111, alu_a_o = alu_b_o = 0.
- RESP:
  - rsp[grant]_valid_o = 1 and rsp[grant]_data_o = result_q; rsp[grant]_err_o = err_q.
  - The other port's valid/data/err are 0.
  - Stay in RESP until rsp[grant]_ready_i = 1, then go to IDLE on that edge.
- Requesters hold valid and payload stable until ready. Payload changes after acceptance have no effect.
- rspN_ready_i is ignored when rspN_valid_o = 0.

## Timing
- Reset (reset=0 at a rising edge):
  - state=IDLE, last_grant=1 (port 0 wins the first contention), grant=0, all registers 0.
  - All ready/valid/err outputs 0; data outputs 0; alu_op_o=4'b1111; busy_o=0.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced. The same rules apply at whatever state reset hits.
- Latency, valid op: accept at edge T0, ISSUE in cycle T0..T1, rsp_valid high from T1 (2nd cycle after accept begins). Minimum 3 cycles per transaction with rsp_ready held high.
- Latency, invalid op: rsp_valid high the cycle after accept; minimum 2 cycles per transaction.
- reqN_ready_o is combinational from reqN_valid_i and state. rsp outputs and alu_* are functions of registered state only.
- Back-to-back contention alternates strictly 0,1,0,1. A lone requester can win repeatedly.
- Simultaneous events: a new request arriving during ISSUE/RESP waits with ready=0. A request during the RESP-exit cycle is not accepted until the following IDLE cycle.

## Test plan
- Reset then single op: req0 op=4'b0000 a=5 b=7 -> ready0 high one cycle, alu_op_o=0000 for exactly one cycle, rsp0_valid high 2 cycles after accept, data=12, err=0.
- Contention from reset: both valid continuously, rsp_ready tied 1 -> grants in order 0,1,0,1; req0 SUB 10-3 -> 7, req1 ADD 1+1 -> 2; never both ready high.
- Backpressure: rsp1_ready_i held 0 for 10 cycles -> rsp1_valid/data stable, busy_o=1, req0 not accepted until 1 cycle after rsp1_ready_i rises.
- Invalid op: req0 op=4'b1111 -> rsp0_valid the cycle after accept, err=1, data=0, alu_op_o stays 1111 throughout.
- Reset mid-transaction: assert reset during ISSUE and separately during RESP -> all outputs return to reset values next edge; no rsp_valid afterward; next contention grants port 0.
- Payload change after accept: req0 changes a/b during ISSUE -> result reflects the captured operands.
